// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg
//   Shared definitions for the front-panel key conditioner: 2-bit FSM state
//   encodings, default tick constants and a counter-width helper.
`timescale 1ns/1ps
package key_debouncer_pkg;

  localparam logic [1:0] ST_RELEASED    = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_TICK_DIV         = 24000;
  localparam int DEF_DEBOUNCE_MS      = 5;
  localparam int DEF_REPEAT_DELAY_MS  = 500;
  localparam int DEF_REPEAT_PERIOD_MS = 100;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..maxval, never less than one.
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/key_debouncer_ms_tick_gen.sv
// ms_tick_gen
//   Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
//   Reusable by any panel key that needs the millisecond debounce timebase.
// Ports
//   clk24    in   system clock
//   reset_n  in   asynchronous active-low reset
//   tick     out  high while the count equals TICK_DIV-1
`timescale 1ns/1ps
module ms_tick_gen
  import key_debouncer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk24,
  input  logic reset_n,
  output logic tick
);

  localparam int TW = cnt_width(TICK_DIV - 1);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer
//   Synchronises the raw active-low step key into clk24, debounces it against
//   the millisecond tick and produces a clean level plus press/repeat strobes.
// Ports
//   clk24          in   system clock
//   reset_n        in   asynchronous active-low reset
//   n_key_raw      in   raw key pin, active low, asynchronous, bouncing
//   repeat_en      in   enables auto-repeat strobes while held
//   n_key_clean    out  debounced key level, active low
//   key_strobe     out  one-cycle pulse on accepted press or each repeat
//   key_is_repeat  out  1 = strobe is a repeat, 0 = initial press
//
// state        | meaning
// RELEASED     | key idle, waiting for a low level
// PRESS_CHK    | low seen, counting stable ticks before accepting press
// HELD         | press accepted, optional auto-repeat timing
// RELEASE_CHK  | high seen while held, counting stable ticks before release
`timescale 1ns/1ps
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int TICK_DIV         = DEF_TICK_DIV,
  parameter int DEBOUNCE_MS      = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS  = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_PERIOD_MS = DEF_REPEAT_PERIOD_MS
) (
  input  logic clk24,
  input  logic reset_n,
  input  logic n_key_raw,
  input  logic repeat_en,
  output logic n_key_clean,
  output logic key_strobe,
  output logic key_is_repeat
);

  localparam int DW = cnt_width(DEBOUNCE_MS);
  localparam int RW = cnt_width(max2(REPEAT_DELAY_MS, REPEAT_PERIOD_MS));

  // Compare against max-1 so the tick that reaches the limit acts at once.
  localparam logic [DW-1:0] DEB_M1  = DW'(DEBOUNCE_MS - 1);
  localparam logic [RW-1:0] RDLY_M1 = RW'(REPEAT_DELAY_MS - 1);
  localparam logic [RW-1:0] RPER_M1 = RW'(REPEAT_PERIOD_MS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [DW-1:0]          r_dcnt;
  logic [RW-1:0]          r_rcnt;
  logic                   r_first;
  logic                   r_n_key_clean;
  logic                   r_key_strobe;
  logic                   r_key_is_repeat;
  logic                   w_ks;
  logic                   w_tick;
  logic [RW-1:0]          w_rep_limit;

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk24   (clk24),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], n_key_raw};
    end
  end

  assign w_ks        = r_sync[SYNC_STAGES-1];
  assign w_rep_limit = r_first ? RDLY_M1 : RPER_M1;

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_RELEASED;
      r_dcnt          <= '0;
      r_rcnt          <= '0;
      r_first         <= 1'b0;
      r_n_key_clean   <= 1'b1;
      r_key_strobe    <= 1'b0;
      r_key_is_repeat <= 1'b0;
    end else begin
      r_key_strobe    <= 1'b0;
      r_key_is_repeat <= 1'b0;
      case (r_state)
        ST_RELEASED: begin
          r_n_key_clean <= 1'b1;
          if (!w_ks) begin
            r_state <= ST_PRESS_CHK;
            r_dcnt  <= '0;
          end
        end
        ST_PRESS_CHK: begin
          if (w_ks) begin
            r_state <= ST_RELEASED;
            r_dcnt  <= '0;
          end else if (w_tick) begin
            if (r_dcnt == DEB_M1) begin
              r_state       <= ST_HELD;
              r_dcnt        <= '0;
              r_n_key_clean <= 1'b0;
              r_key_strobe  <= 1'b1;
              r_rcnt        <= '0;
              r_first       <= 1'b1;
            end else begin
              r_dcnt <= r_dcnt + 1'b1;
            end
          end
        end
        ST_HELD: begin
          if (w_ks) begin
            r_state <= ST_RELEASE_CHK;
            r_dcnt  <= '0;
          end else if (!repeat_en) begin
            r_rcnt  <= '0;
            r_first <= 1'b1;
          end else if (w_tick && !r_key_strobe) begin
            // Skipping a tick that lands on a strobe cycle keeps strobes
            // apart even with a one-cycle tick divider.
            if (r_rcnt == w_rep_limit) begin
              r_key_strobe    <= 1'b1;
              r_key_is_repeat <= 1'b1;
              r_rcnt          <= '0;
              r_first         <= 1'b0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        ST_RELEASE_CHK: begin
          // Returning to HELD keeps the repeat timing so a short glitch only
          // stretches the cadence instead of restarting it.
          if (!w_ks) begin
            r_state <= ST_HELD;
            r_dcnt  <= '0;
          end else if (w_tick) begin
            if (r_dcnt == DEB_M1) begin
              r_state       <= ST_RELEASED;
              r_dcnt        <= '0;
              r_rcnt        <= '0;
              r_first       <= 1'b0;
              r_n_key_clean <= 1'b1;
            end else begin
              r_dcnt <= r_dcnt + 1'b1;
            end
          end
        end
        default: begin
          r_state       <= ST_RELEASED;
          r_dcnt        <= '0;
          r_rcnt        <= '0;
          r_first       <= 1'b0;
          r_n_key_clean <= 1'b1;
        end
      endcase
    end
  end

  assign n_key_clean   = r_n_key_clean;
  assign key_strobe    = r_key_strobe;
  assign key_is_repeat = r_key_is_repeat;

endmodule

// File: tb/tb_key_debouncer.sv
`timescale 1ns/1ps
module tb_key_debouncer;

  logic clk24 = 1'b0;
  logic reset_n;
  logic n_key_raw;
  logic repeat_en;
  logic n_key_clean;
  logic key_strobe;
  logic key_is_repeat;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int consec = 0;
  int rep_bad = 0;
  logic prev_strobe = 1'b0;
  int st_cyc[$];
  int st_rep[$];

  key_debouncer #(
    .SYNC_STAGES      (2),
    .TICK_DIV         (4),
    .DEBOUNCE_MS      (3),
    .REPEAT_DELAY_MS  (5),
    .REPEAT_PERIOD_MS (2)
  ) dut (
    .clk24         (clk24),
    .reset_n       (reset_n),
    .n_key_raw     (n_key_raw),
    .repeat_en     (repeat_en),
    .n_key_clean   (n_key_clean),
    .key_strobe    (key_strobe),
    .key_is_repeat (key_is_repeat)
  );

  always #5 clk24 = ~clk24;

  always @(posedge clk24) cyc++;

  always @(negedge clk24) begin
    if (key_strobe === 1'b1) begin
      st_cyc.push_back(cyc);
      st_rep.push_back(int'(key_is_repeat));
      if (prev_strobe === 1'b1) consec++;
    end else if (key_is_repeat !== 1'b0) begin
      rep_bad++;
    end
    prev_strobe = key_strobe;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk24);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
    checks++;
    assert (got >= lo && got <= hi) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  // Cycles until n_key_clean reaches lvl; -1 if it never does within limit.
  task automatic wait_clean(input logic lvl, input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      step(1);
      if (n_key_clean === lvl) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int n0, n1, n2, lat, bad, found, r_at;

    // 1. reset with key held, then fresh press after release of reset
    reset_n = 1'b0;
    n_key_raw = 1'b0;
    repeat_en = 1'b0;
    step(3);
    chk("rst_clean", n_key_clean, 1);
    chk("rst_strobe", key_strobe, 0);
    chk("rst_is_repeat", key_is_repeat, 0);
    n0 = st_cyc.size();
    reset_n = 1'b1;
    wait_clean(1'b0, 40, lat);
    chk_rng("rst_press_latency", lat, 12, 15);
    step(4);
    chk("rst_press_strobes", st_cyc.size() - n0, 1);
    chk("rst_press_is_repeat", (st_cyc.size() > n0) ? st_rep[n0] : 2, 0);

    n0 = st_cyc.size();
    n_key_raw = 1'b1;
    wait_clean(1'b1, 40, lat);
    chk_rng("rst_release_latency", lat, 12, 15);
    step(4);
    chk("rst_release_no_strobe", st_cyc.size() - n0, 0);

    // 2. bounce rejection
    n0 = st_cyc.size();
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      n_key_raw = ~n_key_raw;
      for (int j = 0; j < 5; j++) begin
        step(1);
        if (n_key_clean !== 1'b1) bad++;
      end
    end
    step(20);
    chk("bounce_clean_high", bad, 0);
    chk("bounce_no_strobe", st_cyc.size() - n0, 0);

    // 3. clean press and release
    n0 = st_cyc.size();
    n_key_raw = 1'b0;
    step(40);
    chk("press_strobes", st_cyc.size() - n0, 1);
    chk("press_is_repeat", (st_cyc.size() > n0) ? st_rep[n0] : 2, 0);
    chk("press_clean_low", n_key_clean, 0);
    n0 = st_cyc.size();
    n_key_raw = 1'b1;
    wait_clean(1'b1, 40, lat);
    chk_rng("release_latency", lat, 12, 15);
    step(5);
    chk("release_no_strobe", st_cyc.size() - n0, 0);

    // 4. auto-repeat cadence: 20 cycles to first repeat, then every 8
    repeat_en = 1'b1;
    n0 = st_cyc.size();
    n_key_raw = 1'b0;
    found = 0;
    for (int k = 0; k < 120; k++) begin
      step(1);
      if (st_cyc.size() >= n0 + 4) begin
        found = 1;
        break;
      end
    end
    chk("rep_four_strobes", found, 1);
    chk("rep_press_is_repeat", (st_cyc.size() > n0) ? st_rep[n0] : 2, 0);
    chk("rep_first_gap", (st_cyc.size() > n0 + 1) ? st_cyc[n0+1] - st_cyc[n0] : -1, 20);
    chk("rep_second_gap", (st_cyc.size() > n0 + 2) ? st_cyc[n0+2] - st_cyc[n0+1] : -1, 8);
    chk("rep_third_gap", (st_cyc.size() > n0 + 3) ? st_cyc[n0+3] - st_cyc[n0+2] : -1, 8);
    chk("rep_flag_1", (st_cyc.size() > n0 + 1) ? st_rep[n0+1] : 2, 1);
    chk("rep_flag_3", (st_cyc.size() > n0 + 3) ? st_rep[n0+3] : 2, 1);
    repeat_en = 1'b0;
    n1 = st_cyc.size();
    step(40);
    chk("rep_disabled_no_strobe", st_cyc.size() - n1, 0);
    chk("rep_disabled_clean_low", n_key_clean, 0);

    // 5. release glitch while held
    repeat_en = 1'b1;
    n1 = st_cyc.size();
    found = 0;
    for (int k = 0; k < 60; k++) begin
      step(1);
      if (st_cyc.size() > n1) begin
        found = 1;
        break;
      end
    end
    chk("glitch_pre_repeat_seen", found, 1);
    r_at = (st_cyc.size() > n1) ? st_cyc[n1] : 0;
    n1 = st_cyc.size();
    bad = 0;
    step(2);
    n_key_raw = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (n_key_clean !== 1'b0) bad++;
    end
    n_key_raw = 1'b0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      step(1);
      if (n_key_clean !== 1'b0) bad++;
      if (st_cyc.size() > n1) begin
        found = 1;
        break;
      end
    end
    chk("glitch_clean_low", bad, 0);
    chk("glitch_next_is_repeat", (st_cyc.size() > n1) ? st_rep[n1] : 2, 1);
    chk_rng("glitch_next_gap", (st_cyc.size() > n1) ? st_cyc[n1] - r_at : -1, 8, 16);

    // 6. async reset in the middle of a strobe
    found = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (key_strobe === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("arst_strobe_seen", found, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_clean", n_key_clean, 1);
    chk("arst_strobe_dropped", key_strobe, 0);
    chk("arst_is_repeat", key_is_repeat, 0);
    n2 = st_cyc.size();
    step(3);
    chk("arst_no_trailing_strobe", st_cyc.size() - n2, 0);
    reset_n = 1'b1;
    wait_clean(1'b0, 40, lat);
    chk_rng("arst_fresh_press_latency", lat, 12, 15);
    step(2);
    chk("arst_fresh_press_strobes", st_cyc.size() - n2, 1);
    chk("arst_fresh_is_repeat", (st_cyc.size() > n2) ? st_rep[n2] : 2, 0);

    chk("no_consecutive_strobes", consec, 0);
    chk("is_repeat_only_with_strobe", rep_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
